// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional divide-by-zero detection is enabled with DIV_ZERO_DETECT_EN.
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Iteration counter width: holds 0 .. width-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_control.sv
// Sequencer for seq_divider: state machine, iteration counter, busy/ready/dz
// registers and the load/shift strobes. dz exists only with DIV_ZERO_DETECT_EN.
module div_control
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
`ifdef DIV_ZERO_DETECT_EN
    input  logic       div_zero,
    output logic       dz,
`endif
    output logic       load,
    output logic       shift,
    output logic       busy,
    output logic       ready,
    output div_state_e state
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          last;
`ifdef DIV_ZERO_DETECT_EN
    logic          dz_q, dz_d;
`endif

    always_comb begin
        load    = (state_q != CALC) && run;
        shift   = (state_q == CALC);
        last    = shift && (count_q == CW'(WIDTH - 1));
        state_d = state_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = dz_q;
`endif
        if (load) begin
            count_d = '0;
            state_d = CALC;
            busy_d  = 1'b1;
            ready_d = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_d    = div_zero;
            // A zero divisor skips iteration; the datapath loads the result directly.
            if (div_zero) begin
                state_d = DONE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
`endif
        end else if (shift) begin
            count_d = count_q + CW'(1);
            if (last) begin
                state_d = DONE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign ready = ready_q;
    assign state = state_q;
`ifdef DIV_ZERO_DETECT_EN
    assign dz    = dz_q;
`endif

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN for the dz port and single-cycle divide-by-zero.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             dz
`endif
);

    // Handshake: run is accepted on any rising edge where the divider is not
    // iterating (IDLE or DONE); operands are sampled only on that edge. ready
    // then drops and rises again once quotient/remainder are final, holding
    // until the next accepted run. run while busy is ignored.

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             load;
    logic             shift;
    div_state_e       ctrl_state;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_zero;

    assign div_zero = (divisor == '0);
`endif

    div_control #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
`ifdef DIV_ZERO_DETECT_EN
        .div_zero (div_zero),
        .dz       (dz),
`endif
        .load     (load),
        .shift    (shift),
        .busy     (busy),
        .ready    (ready),
        .state    (ctrl_state)
    );

    always_comb begin
        // The bit shifted out of rem is kept so wide divisors never lose a carry.
        rem_sh = {rem_q, q_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        rem_d  = rem_q;
        q_d    = q_q;
        dvs_d  = dvs_q;
        if (load) begin
            dvs_d = divisor;
            q_d   = dividend;
            rem_d = '0;
`ifdef DIV_ZERO_DETECT_EN
            if (div_zero) begin
                q_d   = '1;
                rem_d = dividend;
            end
`endif
        end else if (shift) begin
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            q_q   <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            q_q   <= q_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = rem_q;

    a_busy_state : assert property (@(posedge clk) disable iff (rst)
        busy == (ctrl_state == CALC));
    a_ready_state : assert property (@(posedge clk) disable iff (rst)
        ready == (ctrl_state == DONE));

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, hand-written corner
// sequences and random operands checked against an arithmetic reference.
module tb_seq_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         ready;
`ifdef DIV_ZERO_DETECT_EN
    logic         dz;
`endif

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
    } vec_t;

    vec_t vecs[10];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .ready     (ready)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .dz        (dz)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {{W{1'b1}}, a};
        return {a / b, a % b};
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
        return (DZ_EN && b == '0) ? 1 : LAT;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_quot"}, 64'(quotient), 64'(0));
        check({name, "_rem"}, 64'(remainder), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_ready"}, 64'(ready), 64'(0));
`ifdef DIV_ZERO_DETECT_EN
        check({name, "_dz"}, 64'(dz), 64'(0));
`endif
    endtask

    // Waits (bounded) for ready; start_edges = edges since the accepting edge.
    task automatic wait_done(input string name, input int start_edges, input int exp_lat,
                             input logic b_zero);
        int edges;
        int busy_cnt;
        logic [2*W-1:0] e;
        edges    = start_edges;
        busy_cnt = 0;
        while (!ready && edges < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            edges++;
            if (!ready) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
        end
        e = exp_q.pop_front();
        check({name, "_latency"}, 64'(edges), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - start_edges));
        check({name, "_quot"}, 64'(quotient), 64'(e[2*W-1:W]));
        check({name, "_rem"}, 64'(remainder), 64'(e[W-1:0]));
        check({name, "_busy_at_ready"}, 64'(busy), 64'(0));
`ifdef DIV_ZERO_DETECT_EN
        check({name, "_dz"}, 64'(dz), 64'(b_zero));
`else
        if (b_zero) checks += 0;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        run      = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        run      = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic do_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
        exp_q.push_back({eq, er});
        start_op(a, b);
        wait_done(name, 1, ref_lat(b), b == '0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] m;

        vecs[0] = '{a: 32'd100,        b: 32'd7,          eq: 32'd14,         er: 32'd2};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          eq: 32'hFFFF_FFFF,  er: 32'd0};
        vecs[2] = '{a: 32'd5,          b: 32'd10,         eq: 32'd0,          er: 32'd5};
        vecs[3] = '{a: 32'd12345,      b: 32'd0,          eq: 32'hFFFF_FFFF,  er: 32'd12345};
        vecs[4] = '{a: 32'd0,          b: 32'd5,          eq: 32'd0,          er: 32'd0};
        vecs[5] = '{a: 32'd1000,       b: 32'd3,          eq: 32'd333,        er: 32'd1};
        vecs[6] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  eq: 32'd1,          er: 32'd0};
        vecs[7] = '{a: 32'hFFFF_FFFE,  b: 32'hFFFF_FFFF,  eq: 32'd0,          er: 32'hFFFF_FFFE};
        vecs[8] = '{a: 32'h8000_0000,  b: 32'd3,          eq: 32'd715827882,  er: 32'd2};
        vecs[9] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  eq: 32'd1,          er: 32'h7FFF_FFFF};

        rst      = 1'b1;
        run      = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er);
            if (i == 0) begin
                repeat (3) @(negedge clk);
                check("hold_ready", 64'(ready), 64'(1));
                check("hold_quot", 64'(quotient), 64'(14));
                check("hold_rem", 64'(remainder), 64'(2));
            end
        end

        // run pulsed mid-iteration must be ignored
        exp_q.push_back({32'd333, 32'd1});
        start_op(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        run      = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd9;
        @(negedge clk);
        run = 1'b0;
        wait_done("ignore_run", 11, LAT, 1'b0);

        // reset in the middle of an operation
        start_op(32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("mid_reset");
        rst = 1'b0;
        do_div("after_reset", 32'd50, 32'd5, 32'd10, 32'd0);

        // run held continuously: back-to-back operations
        exp_q.push_back({32'd3, 32'd2});
        @(negedge clk);
        run      = 1'b1;
        dividend = 32'd20;
        divisor  = 32'd6;
        @(negedge clk);
        wait_done("held_first", 1, LAT, 1'b0);
        exp_q.push_back({32'd1, 32'd0});
        dividend = 32'd7;
        divisor  = 32'd7;
        @(negedge clk);
        check("held_ready_pulse", 64'(ready), 64'(0));
        check("held_busy_restart", 64'(busy), 64'(1));
        run      = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        wait_done("held_second", 1, LAT, 1'b0);

        // random operands against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 4))
                0: b = W'($urandom_range(1, 15));
                1: b = W'($urandom);
                2: b = a >> $urandom_range(0, 31);
                3: b = '0;
                default: b = W'($urandom_range(1, 65535));
            endcase
            m = ref_div(a, b);
            do_div($sformatf("rand%0d", i), a, b, m[2*W-1:W], m[W-1:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
